// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch counter slice.
// Build option STOPWATCH_LAP_HOLD_EN adds lap/lap_held to the interface and top.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } stopwatch_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;

    // Two BCD digits to binary, used for the minute terminal-count compare.
    function automatic logic [6:0] bcd2_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle between the stopwatch counter and its surroundings.
// With STOPWATCH_LAP_HOLD_EN defined the bundle also carries lap and lap_held.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic       start_stop;
    logic       clear;
    logic       second_tick;
    logic       timer_en;
    bcd_digit_t sec_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t min_ones;
    bcd_digit_t min_tens;
    logic [1:0] state;
    logic       rollover;
`ifdef STOPWATCH_LAP_HOLD_EN
    logic       lap;
    logic       lap_held;

    modport master (
        output start_stop, clear, second_tick, lap,
        input  timer_en, sec_ones, sec_tens, min_ones, min_tens, state, rollover, lap_held
    );
    modport slave (
        input  start_stop, clear, second_tick, lap,
        output timer_en, sec_ones, sec_tens, min_ones, min_tens, state, rollover, lap_held
    );
`else
    modport master (
        output start_stop, clear, second_tick,
        input  timer_en, sec_ones, sec_tens, min_ones, min_tens, state, rollover
    );
    modport slave (
        input  start_stop, clear, second_tick,
        output timer_en, sec_ones, sec_tens, min_ones, min_tens, state, rollover
    );
`endif

endinterface

// File: rtl/stopwatch_counter_bcd.sv
// Single BCD digit with synchronous clear and ripple carry; wraps to 0 after MAX.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       inc,
    input  logic       clr,
    output bcd_digit_t digit,
    output logic       carry_out
);

    localparam bcd_digit_t MAX_D = bcd_digit_t'(MAX);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    assign carry_out = inc && (digit_q == MAX_D);
    assign digit     = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr || carry_out) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch run/pause/idle control plus MM:SS BCD tick counter.
// Optional lap snapshot display is built when STOPWATCH_LAP_HOLD_EN is defined.
//
// state   | meaning
// IDLE    | stopped at 00:00, timer disabled
// RUNNING | timer enabled, ticks counted
// PAUSED  | count frozen, timer disabled
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MINUTE_LIMIT = 60
) (
    input  logic                clk,
    input  logic                n_rst,
    stopwatch_counter_if.slave  sw
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_RUNNING = RUNNING;
    localparam logic [1:0] ST_PAUSED  = PAUSED;
    localparam logic [6:0] MIN_LAST   = 7'(MINUTE_LIMIT - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       rollover_q;
    logic       rollover_d;

    logic running;
    logic count_en;
    logic clear_en;

    assign running  = (state_q == ST_RUNNING);
    assign count_en = running && sw.second_tick;
    assign clear_en = sw.clear && !running;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sw.clear)           state_d = ST_IDLE;
                else if (sw.start_stop) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (sw.start_stop)      state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (sw.clear)           state_d = ST_IDLE;
                else if (sw.start_stop) state_d = ST_RUNNING;
            end
            default:                    state_d = ST_IDLE;
        endcase
    end

    bcd_digit_t sec_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t min_ones;
    bcd_digit_t min_tens;
    logic       so_carry;
    logic       st_carry;
    logic       mo_carry;
    logic       mt_carry;
    logic       min_wrap;
    logic       min_clr;

    // Minutes are a BCD pair that wraps early on a terminal-count compare.
    assign min_wrap   = st_carry && (bcd2_to_bin(min_tens, min_ones) == MIN_LAST);
    assign min_clr    = clear_en || min_wrap;
    assign rollover_d = min_wrap || mt_carry;

    bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .n_rst(n_rst), .inc(count_en), .clr(clear_en),
        .digit(sec_ones), .carry_out(so_carry)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .n_rst(n_rst), .inc(so_carry), .clr(clear_en),
        .digit(sec_tens), .carry_out(st_carry)
    );

    bcd_digit_counter #(.MAX(9)) u_min_ones (
        .clk(clk), .n_rst(n_rst), .inc(st_carry), .clr(min_clr),
        .digit(min_ones), .carry_out(mo_carry)
    );

    bcd_digit_counter #(.MAX(9)) u_min_tens (
        .clk(clk), .n_rst(n_rst), .inc(mo_carry), .clr(min_clr),
        .digit(min_tens), .carry_out(mt_carry)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rollover_q <= rollover_d;
        end
    end

    assign sw.timer_en = running;
    assign sw.state    = state_q;
    assign sw.rollover = rollover_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        lap_held_q;
    logic        lap_held_d;
    logic [15:0] snap_q;
    logic [15:0] snap_d;
    logic [15:0] live;

    assign live = {min_tens, min_ones, sec_tens, sec_ones};

    // Leaving RUNNING always drops the hold, so IDLE/PAUSED never show a snapshot.
    always_comb begin
        lap_held_d = lap_held_q;
        snap_d     = snap_q;
        if (!running || state_d != ST_RUNNING) begin
            lap_held_d = 1'b0;
        end else if (sw.lap) begin
            lap_held_d = !lap_held_q;
            if (!lap_held_q) snap_d = live;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lap_held_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            lap_held_q <= lap_held_d;
            snap_q     <= snap_d;
        end
    end

    assign sw.lap_held = lap_held_q;
    assign sw.min_tens = lap_held_q ? snap_q[15:12] : min_tens;
    assign sw.min_ones = lap_held_q ? snap_q[11:8]  : min_ones;
    assign sw.sec_tens = lap_held_q ? snap_q[7:4]   : sec_tens;
    assign sw.sec_ones = lap_held_q ? snap_q[3:0]   : sec_ones;
`else
    assign sw.min_tens = min_tens;
    assign sw.min_ones = min_ones;
    assign sw.sec_tens = sec_tens;
    assign sw.sec_ones = sec_ones;
`endif

endmodule
